// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    ACCEPT,
    HELD
  } state_t;

  // Indexed [row][col]; '*' maps to E and '#' maps to F.
  localparam logic [3:0] KEYMAP [NUM_ROWS][NUM_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

endpackage

// File: rtl/module_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs.
module module_sync2 #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/module_keypad_scanner.sv
// 4x4 keypad scanner: column strobe, sampled row debounce, hex encode,
// single-cycle press event plus held level.
module module_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 27000,
  parameter int unsigned STABLE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(STABLE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_SCANS - 1);

  logic [NUM_ROWS-1:0] w_row_s;
  logic [NUM_ROWS-1:0] w_low;
  logic                w_sample;
  logic                w_none;
  logic                w_multi;
  logic                w_one;
  logic [1:0]          w_one_row;
  logic                w_match;
  logic [3:0]          w_code;

  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col_idx;
  state_t        r_state;
  logic [1:0]    r_cand_row;
  logic [CW-1:0] r_stable_cnt;
  logic [CW-1:0] r_rel_cnt;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_held;

  module_sync2 #(
    .WIDTH   (NUM_ROWS),
    .RST_VAL ('1)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .i_d (row),
    .o_q (w_row_s)
  );

  assign w_sample = (r_dwell == DWELL_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dwell <= '0;
    end else if (w_sample) begin
      r_dwell <= '0;
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  always_comb begin
    w_low     = ~w_row_s;
    w_none    = (w_low == '0);
    w_multi   = ((w_low & (w_low - NUM_ROWS'(1))) != '0);
    w_one     = !w_none && !w_multi;
    w_one_row = '0;
    for (int unsigned i = 0; i < NUM_ROWS; i++) begin
      if (w_low[i]) w_one_row = 2'(i);
    end
    w_match = w_one && (w_one_row == r_cand_row);
  end

  // Column index is frozen outside SCAN, so it doubles as the candidate column.
  assign w_code = KEYMAP[w_one_row][r_col_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= SCAN;
      r_col_idx    <= '0;
      r_cand_row   <= '0;
      r_stable_cnt <= '0;
      r_rel_cnt    <= '0;
      r_key_code   <= '0;
      r_key_valid  <= 1'b0;
      r_key_held   <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        SCAN: begin
          if (w_sample) begin
            if (w_one) begin
              r_cand_row   <= w_one_row;
              r_stable_cnt <= CW'(1);
              if (STABLE_SCANS == 1) begin
                r_key_code  <= w_code;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
                r_state     <= ACCEPT;
              end else begin
                r_state <= CONFIRM;
              end
            end else begin
              r_col_idx <= r_col_idx + 2'd1;
            end
          end
        end
        CONFIRM: begin
          if (w_sample) begin
            if (w_match) begin
              r_stable_cnt <= r_stable_cnt + CW'(1);
              if (r_stable_cnt == CNT_LAST) begin
                r_key_code  <= w_code;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
                r_state     <= ACCEPT;
              end
            end else begin
              r_stable_cnt <= '0;
              r_col_idx    <= r_col_idx + 2'd1;
              r_state      <= SCAN;
            end
          end
        end
        ACCEPT: begin
          r_stable_cnt <= '0;
          r_rel_cnt    <= '0;
          r_state      <= HELD;
        end
        HELD: begin
          if (w_sample) begin
            if (w_none) begin
              if (r_rel_cnt == CNT_LAST) begin
                r_rel_cnt  <= '0;
                r_key_held <= 1'b0;
                r_col_idx  <= r_col_idx + 2'd1;
                r_state    <= SCAN;
              end else begin
                r_rel_cnt <= r_rel_cnt + CW'(1);
              end
            end else begin
              r_rel_cnt <= '0;
            end
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  assign col       = ~(4'b0001 << r_col_idx);
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_module_keypad_scanner.sv
// Self-checking bench for module_keypad_scanner: keypad matrix model in the
// loop, per-cycle reference comparison, vector table and corner sequences.
module tb_module_keypad_scanner;

  localparam int DIV  = 4;
  localparam int STAB = 2;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  module_keypad_scanner #(
    .SCAN_DIV     (DIV),
    .STABLE_SCANS (STAB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pressed-key set: bit index = row*4 + col.
  logic [15:0] mask;

  // Hex value printed on each key, row-major.
  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  // Reference model state
  int         m_dwell, m_idx, m_phase, m_cnt, m_rel, m_cr;
  logic [3:0] m_s1, m_s2, m_code;
  logic       m_valid, m_held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] keypad(input logic [15:0] m, input logic [3:0] c);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (m[ri*4+ci] && !c[ci]) r[ri] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] m_col();
    logic [3:0] v;
    v = 4'hF;
    v[m_idx] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    m_dwell = 0; m_idx = 0; m_phase = 0; m_cnt = 0; m_rel = 0; m_cr = 0;
    m_s1 = 4'hF; m_s2 = 4'hF; m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
  endtask

  // phase: 0 scanning, 1 confirming, 2 accept cycle, 3 held
  task automatic model_step(input logic [3:0] rin);
    int nlow, lowr;
    nlow = 0; lowr = 0;
    for (int i = 0; i < 4; i++) if (!m_s2[i]) begin nlow++; lowr = i; end
    m_valid = 1'b0;
    if (m_phase == 2) begin
      m_phase = 3; m_rel = 0;
    end else if (m_dwell == DIV - 1) begin
      case (m_phase)
        0: if (nlow == 1) begin
             m_cr = lowr; m_cnt = 1;
             if (m_cnt >= STAB) begin
               m_code = 4'(keymap[m_cr*4+m_idx]); m_valid = 1'b1; m_held = 1'b1; m_phase = 2;
             end else m_phase = 1;
           end else m_idx = (m_idx + 1) % 4;
        1: if (nlow == 1 && lowr == m_cr) begin
             m_cnt++;
             if (m_cnt >= STAB) begin
               m_code = 4'(keymap[m_cr*4+m_idx]); m_valid = 1'b1; m_held = 1'b1; m_phase = 2;
             end
           end else begin
             m_cnt = 0; m_idx = (m_idx + 1) % 4; m_phase = 0;
           end
        3: if (nlow == 0) begin
             m_rel++;
             if (m_rel >= STAB) begin m_held = 1'b0; m_idx = (m_idx + 1) % 4; m_phase = 0; end
           end else m_rel = 0;
        default: ;
      endcase
    end
    m_dwell = (m_dwell + 1) % DIV;
    m_s2 = m_s1;
    m_s1 = rin;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step(row); else model_reset();
    #1;
    check("col", 32'(col), 32'(m_col()));
    check("key_code", 32'(key_code), 32'(m_code));
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_held", 32'(key_held), 32'(m_held));
    row = keypad(mask, col);
  endtask

  typedef struct {
    logic [15:0] mask;
    int          cycles;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic        exp_held;
    logic        chk_next;
    logic [3:0]  next_col;
  } vec_t;

  vec_t vecs [8];
  logic [3:0] pat [4];

  initial begin
    int pulses;
    logic [3:0] start_col, next_col;
    logic got_next;

    vecs[0] = '{16'h0020, 40, 1, 4'h5, 1'b1, 1'b0, 4'h0};  // '5'
    vecs[1] = '{16'h0000, 40, 0, 4'h5, 1'b0, 1'b1, 4'hB};  // release, resume at 1011
    vecs[2] = '{16'h0110, 40, 0, 4'h5, 1'b0, 1'b0, 4'h0};  // ghost: '4'+'7' share col0
    vecs[3] = '{16'h4000, 40, 1, 4'hF, 1'b1, 1'b0, 4'h0};  // '#'
    vecs[4] = '{16'h4001, 40, 0, 4'hF, 1'b1, 1'b0, 4'h0};  // '#' plus '1'
    vecs[5] = '{16'h0000, 40, 0, 4'hF, 1'b0, 1'b0, 4'h0};
    vecs[6] = '{16'h2000, 40, 1, 4'h0, 1'b1, 1'b0, 4'h0};  // '0'
    vecs[7] = '{16'h0000, 40, 0, 4'h0, 1'b0, 1'b0, 4'h0};
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;

    // Reset with random rows
    rst = 1'b0; mask = '0; row = 4'($urandom);
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_col", 32'(col), 32'h E);
      check("rst_valid", 32'(key_valid), 32'h0);
      check("rst_held", 32'(key_held), 32'h0);
      check("rst_code", 32'(key_code), 32'h0);
      row = 4'($urandom);
    end
    row = 4'hF;
    rst = 1'b1;

    // Idle column rotation, 4 cycles per column
    check("col_seq", 32'(col), 32'(pat[0]));
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("col_seq", 32'(col), 32'(pat[(i / 4) % 4]));
    end

    // Vector table
    for (int v = 0; v < 8; v++) begin
      mask = vecs[v].mask;
      row = keypad(mask, col);
      pulses = 0; start_col = col; got_next = 1'b0; next_col = col;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        tick();
        if (key_valid) pulses++;
        if (!got_next && col != start_col) begin got_next = 1'b1; next_col = col; end
      end
      check($sformatf("vec%0d_pulses", v), 32'(pulses), 32'(vecs[v].exp_pulses));
      check($sformatf("vec%0d_code", v), 32'(key_code), 32'(vecs[v].exp_code));
      check($sformatf("vec%0d_held", v), 32'(key_held), 32'(vecs[v].exp_held));
      if (v == 0) check("held_col", 32'(col), 32'hD);
      if (vecs[v].chk_next) check($sformatf("vec%0d_next_col", v), 32'(next_col), 32'(vecs[v].next_col));
    end

    // Bounce: '5' visible at exactly one sample on col 1101
    @(posedge clk); #1;
    rst = 1'b0; mask = '0; row = 4'hF;
    tick();
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (key_valid) pulses++; end
    mask = 16'h0020;
    for (int i = 0; i < 4; i++) begin tick(); if (key_valid) pulses++; end
    mask = '0;
    for (int i = 0; i < 5; i++) begin tick(); if (key_valid) pulses++; end
    check("bounce_pulses", 32'(pulses), 32'h0);
    check("bounce_col", 32'(col), 32'hB);
    check("bounce_code", 32'(key_code), 32'h0);

    // Reset while a key is held
    mask = 16'h0020;
    for (int i = 0; i < 40; i++) tick();
    check("pre_rst_held", 32'(key_held), 32'h1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_held", 32'(key_held), 32'h0);
    check("async_col", 32'(col), 32'hE);
    check("async_valid", 32'(key_valid), 32'h0);
    row = keypad(mask, col);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (key_valid) pulses++; end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(); if (key_valid) pulses++; end
    check("rst_held_pulses", 32'(pulses), 32'h0);
    mask = '0;
    for (int i = 0; i < 40; i++) tick();

    // Random key activity against the reference model
    for (int s = 0; s < 80; s++) begin
      int kind, dur;
      kind = int'($urandom_range(0, 9));
      dur  = int'($urandom_range(2, 40));
      if (kind < 2) mask = '0;
      else if (kind < 8) begin mask = '0; mask[$urandom_range(0, 15)] = 1'b1; end
      else begin
        mask = '0;
        mask[$urandom_range(0, 15)] = 1'b1;
        mask[$urandom_range(0, 15)] = 1'b1;
      end
      for (int c = 0; c < dur; c++) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
